// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file write side.
//   DATA_WIDTH / ADDR_WIDTH / NUM_REGS : register file geometry
//   MAX_WAIT                           : default starvation bound for loads
//   wb_src_e                           : which producer owns the write port
//   pick_source()                      : writeback arbitration rule
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 1 << ADDR_WIDTH;
    localparam int MAX_WAIT   = 3;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2
    } wb_src_e;

    // ALU wins by default; memory wins only once it has been refused long
    // enough (mem_priority). A lone valid source is always granted.
    function automatic wb_src_e pick_source(input logic alu_valid,
                                            input logic mem_valid,
                                            input logic mem_priority);
        wb_src_e src;
        src = WB_NONE;
        if (alu_valid && mem_valid) begin
            src = mem_priority ? WB_MEM : WB_ALU;
        end else if (alu_valid) begin
            src = WB_ALU;
        end else if (mem_valid) begin
            src = WB_MEM;
        end
        return src;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Busy-bit scoreboard: one bit per architectural register, set when an
// instruction that writes the register issues, cleared when the write port
// commits to it.
//   clk, rst     : clock, asynchronous active-high reset
//   issue_valid  : an instruction with a destination issues this cycle
//   issue_rd     : its destination register
//   wr_en        : register file write enable (registered write stage)
//   w_addr       : register file write address
//   busy         : bit i set means register i has a result in flight
// ---------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    input  logic [ADDR_WIDTH-1:0]         issue_rd,
    input  logic                          wr_en,
    input  logic [ADDR_WIDTH-1:0]         w_addr,
    output logic [(1 << ADDR_WIDTH)-1:0]  busy
);

    logic [(1 << ADDR_WIDTH)-1:0] busy_next;

    // Clear first, then set: when a writeback and a new issue hit the same
    // register in one cycle, the newer producer is still in flight, so the
    // bit must stay set. Register 0 is hardwired and never tracked.
    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[w_addr] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/rf_writeback.sv
// ---------------------------------------------------------------------------
// rf_writeback
// Write-side front end of the 32x32 register file. Two producers (ALU and
// memory load path) offer results; one is accepted per cycle and written
// through a single registered write stage. A busy-bit scoreboard tracks
// registers with results in flight.
//
// Handshake (both sources): a transfer happens in a cycle where valid and
// ready are both 1. The source holds valid/rd/data stable until accepted;
// it may drop valid without a transfer. ready is purely combinational on
// the current valids and the starvation counter, never on the write stage.
//
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   alu_valid/ready/rd/data: ALU writeback handshake
//   mem_valid/ready/rd/data: load writeback handshake
//   issue_valid, issue_rd  : destination of the instruction issuing now
//   wr_en, w_addr, w_data  : register file write port (registered)
//   busy                   : scoreboard, one bit per register
// ---------------------------------------------------------------------------
module rf_writeback
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH,
    parameter int MAX_WAIT   = rf_pkg::MAX_WAIT
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [ADDR_WIDTH-1:0]         alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_data,

    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [ADDR_WIDTH-1:0]         mem_rd,
    input  logic [DATA_WIDTH-1:0]         mem_data,

    input  logic                          issue_valid,
    input  logic [ADDR_WIDTH-1:0]         issue_rd,

    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         w_addr,
    output logic [DATA_WIDTH-1:0]         w_data,

    output logic [(1 << ADDR_WIDTH)-1:0]  busy
);

    // Counter just wide enough to hold MAX_WAIT (at least one bit).
    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0]     wait_cnt;
    logic                  mem_priority;
    wb_src_e               grant;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign mem_priority = (wait_cnt == WAIT_LIMIT);

    always_comb begin
        grant    = pick_source(alu_valid, mem_valid, mem_priority);
        sel_rd   = alu_rd;
        sel_data = alu_data;
        if (grant == WB_MEM) begin
            sel_rd   = mem_rd;
            sel_data = mem_data;
        end
    end

    assign alu_ready = (grant == WB_ALU);
    assign mem_ready = (grant == WB_MEM);

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive cycles in which a pending
    // load was refused. Any load acceptance, or the load path going idle,
    // restarts the count, so priority is only earned by continuous waiting.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!mem_valid || mem_ready) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write stage. Address and data follow every acceptance, including
    // writes to register 0; only the enable filters out the hardwired zero
    // register. Without an acceptance the enable drops and the address and
    // data simply hold.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en  <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
        end else if (grant != WB_NONE) begin
            wr_en  <= (sel_rd != '0);
            w_addr <= sel_rd;
            w_data <= sel_data;
        end else begin
            wr_en  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard, cleared by the registered write port so a bit drops at
    // the same edge the register file commits the value.
    // ------------------------------------------------------------------
    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wr_en       (wr_en),
        .w_addr      (w_addr),
        .busy        (busy)
    );

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Write-side front end for the 32x32 register file. Accepts writeback results from two producers, the single-cycle ALU path and the memory load path, over valid/ready handshakes, and arbitrates between them with a starvation guard. Drives the register file's single write port from a registered stage. Keeps a busy-bit scoreboard of registers with results in flight, so issue logic can stall on RAW hazards.

## Interface
- DATA_WIDTH, 32, bits per register
- ADDR_WIDTH, 5, register address bits (2**ADDR_WIDTH registers)
- MAX_WAIT, 3, consecutive refused memory cycles before memory gets priority

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- alu_valid  in  1  ALU result present
- alu_ready  out  1  ALU result accepted this cycle when valid
- alu_rd  in  ADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- mem_valid  in  1  load result present
- mem_ready  out  1  load result accepted this cycle when valid
- mem_rd  in  ADDR_WIDTH  load destination register
- mem_data  in  DATA_WIDTH  load result
- issue_valid  in  1  an instruction with a destination register issues this cycle
- issue_rd  in  ADDR_WIDTH  destination of the issuing instruction
- wr_en  out  1  register file write enable
- w_addr  out  ADDR_WIDTH  register file write address
- w_data  out  DATA_WIDTH  register file write data
- busy  out  2**ADDR_WIDTH  scoreboard; bit i set means register i has a pending result

## Operation
- Arbitration is combinational on the current valids and the wait counter. Exactly one source is granted per cycle; grant means ready=1.
  - Default: ALU has priority.
  - Memory has priority when wait_cnt == MAX_WAIT.
  - If only one source is valid, it is granted.
  - The ready of a non-granted source is 0.
- Ready is independent of the stage state. There is no downstream backpressure.
- wait_cnt:
  - Width is ceil(log2(MAX_WAIT+1)).
  - Increments, saturating at MAX_WAIT, when mem_valid && !mem_ready.
  - Clears on memory acceptance or when mem_valid=0.
- Output stage:
  - On acceptance, the next edge loads w_addr/w_data from the granted source.
  - wr_en=1 for that one cycle only if rd != 0.
  - A result with rd == 0 is accepted and silently dropped: wr_en=0, scoreboard untouched.
  - With no acceptance, wr_en=0 next cycle. w_addr/w_data hold their last values.
- Scoreboard, updated at the edge:
  - issue_valid && issue_rd != 0 sets busy[issue_rd].
  - wr_en=1 clears busy[w_addr].
  - If both target the same register in the same cycle, the set wins (new producer in flight).
  - busy[0] is always 0.
  - Writeback for a register that is not busy still writes and leaves the bit 0. This is not an error.

## Timing
- Reset values:
  - wr_en=0, w_addr=0, w_data=0.
  - busy all 0, wait_cnt=0.
  - alu_ready/mem_ready follow the combinational rules, so they are 0 while no valid is asserted.
- Latency: acceptance at edge N gives wr_en high during cycle N+1. The register file commits at edge N+1, and busy clears at edge N+1.
- Throughput is one writeback per cycle.
- Under sustained dual traffic, memory is accepted at least once every MAX_WAIT+1 cycles.
- Reset asserted mid-operation:
  - Immediately clears the pending write (wr_en=0), scoreboard and counter.
  - An in-flight accepted result is lost. Upstream flushes on the same reset.
- Source handshake rules:
  - A source must hold valid, rd and data stable until accepted.
  - Dropping valid without acceptance is permitted and clears wait_cnt for memory.

## Structure
- Shared package rf_pkg: DATA_WIDTH, ADDR_WIDTH and NUM_REGS constants.
- rf_pkg also holds the wb_src_e enum {WB_NONE, WB_ALU, WB_MEM}, used for the grant signal and for the bench.
- One sub-module, rf_scoreboard: inputs issue_valid/issue_rd and wr_en/w_addr, output busy. Implements the set/clear priority and the bit-0 rule.
- Arbiter, wait counter and output register stay in rf_writeback.

## Test plan
- After reset, alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle → alu_ready=1; next cycle wr_en=1, w_addr=5, w_data=0xDEADBEEF; following cycle wr_en=0.
- issue rd=7, then 3 cycles later mem writeback rd=7, data=0x1234 → busy[7]=1 from the edge after issue until the edge where wr_en=1; then busy[7]=0.
- alu_valid and mem_valid held high continuously with MAX_WAIT=3 → mem_ready=0 for 3 cycles, then mem_ready=1 and alu_ready=0 for one cycle; the pattern repeats every 4 cycles.
- Same-cycle issue rd=9 and wr_en/w_addr=9 → busy[9]=1 afterwards. Issue rd=0 → busy unchanged. ALU writeback rd=0 → alu_ready=1, wr_en stays 0.
- Accept ALU rd=4, assert rst in the following cycle before the edge → wr_en=0, busy=0 and wait_cnt=0 immediately; no write to register 4 after rst deasserts.
